// File: rtl/bt_txbuf_pkg.sv
// Shared definitions for the ACL TX ping-pong payload buffer.
// Contents: default address width, FSM states, ARQ send-decision encoding and decoder.
package bt_txbuf_pkg;

  localparam int unsigned AW_DEF    = 5;
  localparam int unsigned DEPTH_DEF = 2 ** AW_DEF;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } txbuf_state_e;

  typedef enum logic [1:0] {
    DEC_NEW  = 2'd0,
    DEC_OLD  = 2'd1,
    DEC_ZERO = 2'd2,
    DEC_NONE = 2'd3
  } send_dec_e;

  // First asserted request wins: new, then old, then zero-length.
  function automatic send_dec_e send_decode(input logic new_py, input logic old_py,
                                            input logic zero_py);
    if (new_py)       return DEC_NEW;
    else if (old_py)  return DEC_OLD;
    else if (zero_py) return DEC_ZERO;
    else              return DEC_NONE;
  endfunction

endpackage

// File: rtl/acl_txbuf_ctrl_if.sv
// MCU-side and payload-encoder-side signals of the ACL TX buffer controller.
// master: MCU / link controller / encoder side (drives requests, receives payload).
// slave : the buffer controller.
interface acl_txbuf_ctrl_if
  import bt_txbuf_pkg::*;
#(
  parameter int unsigned AW = AW_DEF
);

  // connection entry
  logic          m_2active_p;
  logic          s_2active_p;
  // MCU fill side
  logic          mcu_wr_p;
  logic [7:0]    mcu_wdata;
  logic          mcu_commit_p;
  logic [AW:0]   mcu_commit_len;
  logic          mcu_flush_p;
  // TX slot / ARQ decision
  logic          pk_encode;
  logic          header_st_p;
  logic          txpktype_data;
  logic          sendnewpy;
  logic          sendoldpy;
  logic          send0py;
  // payload encoder read side
  logic          py_rd_p;
  logic          ms_TXslot_endp;
  logic          py_valid;
  logic [AW:0]   py_len;
  logic [7:0]    py_byte;
  logic          py_last_p;
  // status
  logic          fill_full;
  logic          cur_valid;
  logic          ovf_err;

  modport master (
    output m_2active_p, s_2active_p, mcu_wr_p, mcu_wdata, mcu_commit_p, mcu_commit_len,
           mcu_flush_p, pk_encode, header_st_p, txpktype_data, sendnewpy, sendoldpy,
           send0py, py_rd_p, ms_TXslot_endp,
    input  py_valid, py_len, py_byte, py_last_p, fill_full, cur_valid, ovf_err
  );

  modport slave (
    input  m_2active_p, s_2active_p, mcu_wr_p, mcu_wdata, mcu_commit_p, mcu_commit_len,
           mcu_flush_p, pk_encode, header_st_p, txpktype_data, sendnewpy, sendoldpy,
           send0py, py_rd_p, ms_TXslot_endp,
    output py_valid, py_len, py_byte, py_last_p, fill_full, cur_valid, ovf_err
  );

endinterface

// File: rtl/acl_txbuf_ram.sv
// Two payload buffers of DEPTH bytes each, one write port, one registered read port.
// Ports:
//   clk_6M, rstz          clock, async active-low reset (read register only)
//   we/wr_buf/wr_addr/wdata  byte write into buffer wr_buf
//   re/rd_buf/rd_addr     read request; rdata returns 0 the cycle after re=0
//   rdata                 registered read byte
module acl_txbuf_ram
  import bt_txbuf_pkg::*;
#(
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clk_6M,
  input  logic          rstz,
  input  logic          we,
  input  logic          wr_buf,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic          rd_buf,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rdata
);

  localparam int unsigned DEPTH = 2 ** AW;

  // buffer select is the MSB of the flat index
  logic [7:0] mem [2*DEPTH];

  // storage array, no reset needed: contents only read after being written
  always_ff @(posedge clk_6M) begin
    if (we) mem[{wr_buf, wr_addr}] <= wdata;
  end

  // read register: zero when no byte is being presented
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz)   rdata <= 8'h00;
    else if (re) rdata <= mem[{rd_buf, rd_addr}];
    else         rdata <= 8'h00;
  end

endmodule

// File: rtl/acl_txbuf_ctrl.sv
// ACL TX payload source: ping-pong buffer pair between MCU and payload encoder.
// At each data-packet header the ARQ decision selects new payload, the un-ACKed
// payload again, or zero length; the selected payload is then streamed byte-serially.
// A buffer is only released for refilling once a following sendnewpy implies its ACK.
// Ports:
//   clk_6M  6 MHz baseband clock
//   rstz    asynchronous active-low reset
//   bus     acl_txbuf_ctrl_if.slave: MCU fill, ARQ decision, encoder read, status
module acl_txbuf_ctrl
  import bt_txbuf_pkg::*;
#(
  parameter int unsigned AW = AW_DEF
) (
  input  logic           clk_6M,
  input  logic           rstz,
  acl_txbuf_ctrl_if.slave bus
);

  localparam int unsigned LW    = AW + 1;
  localparam int unsigned DEPTH = 2 ** AW;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] ONE_L   = LW'(1);

  txbuf_state_e  state, state_n;
  logic          cur_sel, cur_sel_n;
  logic          pend_valid, pend_valid_n;
  logic [LW-1:0] pend_len, pend_len_n;
  logic [LW-1:0] cur_len, cur_len_n;
  logic          cur_valid, cur_valid_n;
  logic [LW-1:0] wr_ptr, wr_ptr_n;
  logic [LW-1:0] rd_ptr, rd_ptr_n;
  logic          ovf_err, ovf_err_n;
  logic          py_valid, py_valid_n;
  logic [LW-1:0] py_len, py_len_n;
  logic          py_last, py_last_n;

  logic          accept;
  send_dec_e     dec;
  logic [LW-1:0] len_sel;
  logic          we;
  logic          fill_sel;
  logic          re;
  logic          rd_buf;
  logic [AW-1:0] rd_addr;
  logic [7:0]    py_byte;

  assign fill_sel = ~cur_sel;
  assign accept   = (state == ST_IDLE) && bus.header_st_p && bus.pk_encode && bus.txpktype_data;
  assign dec      = send_decode(bus.sendnewpy, bus.sendoldpy, bus.send0py);

  // state register
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      state      <= ST_IDLE;
      cur_sel    <= 1'b0;
      pend_valid <= 1'b0;
      pend_len   <= '0;
      cur_len    <= '0;
      cur_valid  <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ovf_err    <= 1'b0;
      py_valid   <= 1'b0;
      py_len     <= '0;
      py_last    <= 1'b0;
    end else begin
      state      <= state_n;
      cur_sel    <= cur_sel_n;
      pend_valid <= pend_valid_n;
      pend_len   <= pend_len_n;
      cur_len    <= cur_len_n;
      cur_valid  <= cur_valid_n;
      wr_ptr     <= wr_ptr_n;
      rd_ptr     <= rd_ptr_n;
      ovf_err    <= ovf_err_n;
      py_valid   <= py_valid_n;
      py_len     <= py_len_n;
      py_last    <= py_last_n;
    end
  end

  // next state: MCU fill, ARQ decision, read session, then flush and connect overrides
  always_comb begin
    state_n      = state;
    cur_sel_n    = cur_sel;
    pend_valid_n = pend_valid;
    pend_len_n   = pend_len;
    cur_len_n    = cur_len;
    cur_valid_n  = cur_valid;
    wr_ptr_n     = wr_ptr;
    rd_ptr_n     = rd_ptr;
    ovf_err_n    = ovf_err;
    py_valid_n   = py_valid;
    py_len_n     = py_len;
    py_last_n    = 1'b0;
    len_sel      = '0;
    we           = 1'b0;
    re           = 1'b0;
    rd_buf       = cur_sel;
    rd_addr      = '0;

    // MCU writes land in the fill buffer; refused while pending or full
    if (bus.mcu_wr_p) begin
      if (pend_valid || (wr_ptr == DEPTH_L)) begin
        ovf_err_n = 1'b1;
      end else begin
        we       = 1'b1;
        wr_ptr_n = wr_ptr + ONE_L;
      end
    end

    // commit judged against pre-edge pend_valid, so it cannot collide with a swap
    if (bus.mcu_commit_p) begin
      if (pend_valid) begin
        ovf_err_n = 1'b1;
      end else begin
        pend_valid_n = 1'b1;
        pend_len_n   = (bus.mcu_commit_len > DEPTH_L) ? DEPTH_L : bus.mcu_commit_len;
        wr_ptr_n     = '0;
      end
    end

    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_n    = ST_READ;
          py_valid_n = 1'b1;
          rd_ptr_n   = '0;
          case (dec)
            DEC_NEW: begin
              if (pend_valid) begin
                cur_sel_n    = ~cur_sel;
                cur_len_n    = pend_len;
                cur_valid_n  = 1'b1;
                pend_valid_n = 1'b0;
                len_sel      = pend_len;
              end else begin
                cur_valid_n = 1'b0;
              end
            end
            DEC_OLD:  len_sel = cur_valid ? cur_len : '0;
            DEC_ZERO: cur_valid_n = 1'b0;
            default:  len_sel = '0;
          endcase
          py_len_n = len_sel;
          // prefetch byte 0 of the (possibly new) current buffer
          if (len_sel != '0) begin
            re     = 1'b1;
            rd_buf = cur_sel_n;
          end
        end
      end

      ST_READ: begin
        if (bus.ms_TXslot_endp || (py_len == '0)) begin
          state_n    = ST_IDLE;
          py_valid_n = 1'b0;
        end else if (bus.py_rd_p && (rd_ptr < py_len)) begin
          rd_ptr_n = rd_ptr + ONE_L;
          if (rd_ptr == (py_len - ONE_L)) begin
            py_last_n  = 1'b1;
            state_n    = ST_IDLE;
            py_valid_n = 1'b0;
          end else begin
            re      = 1'b1;
            rd_addr = rd_ptr_n[AW-1:0];
          end
        end else begin
          // hold the presented byte; current buffer is never written
          re      = 1'b1;
          rd_addr = rd_ptr[AW-1:0];
        end
      end

      default: state_n = ST_IDLE;
    endcase

    // flush lands after any swap: only the fill side is discarded
    if (bus.mcu_flush_p) begin
      pend_valid_n = 1'b0;
      wr_ptr_n     = '0;
      ovf_err_n    = 1'b0;
    end

    // connection entry overrides everything, including an active read
    if (bus.m_2active_p || bus.s_2active_p) begin
      state_n      = ST_IDLE;
      cur_sel_n    = 1'b0;
      pend_valid_n = 1'b0;
      pend_len_n   = '0;
      cur_len_n    = '0;
      cur_valid_n  = 1'b0;
      wr_ptr_n     = '0;
      rd_ptr_n     = '0;
      ovf_err_n    = 1'b0;
      py_valid_n   = 1'b0;
      py_len_n     = '0;
      py_last_n    = 1'b0;
      we           = 1'b0;
      re           = 1'b0;
    end
  end

  acl_txbuf_ram #(.AW(AW)) u_ram (
    .clk_6M  (clk_6M),
    .rstz    (rstz),
    .we      (we),
    .wr_buf  (fill_sel),
    .wr_addr (wr_ptr[AW-1:0]),
    .wdata   (bus.mcu_wdata),
    .re      (re),
    .rd_buf  (rd_buf),
    .rd_addr (rd_addr),
    .rdata   (py_byte)
  );

  assign bus.py_valid  = py_valid;
  assign bus.py_len    = py_len;
  assign bus.py_byte   = py_byte;
  assign bus.py_last_p = py_last;
  assign bus.fill_full = pend_valid;
  assign bus.cur_valid = cur_valid;
  assign bus.ovf_err   = ovf_err;

endmodule

// File: tb/tb_acl_txbuf_ctrl.sv
// Self-checking bench for acl_txbuf_ctrl: directed scenarios then random traffic,
// checked against a payload-level model (fill / pending / current byte queues).
module tb_acl_txbuf_ctrl;
  import bt_txbuf_pkg::*;

  localparam int unsigned AW    = AW_DEF;
  localparam int unsigned LW    = AW + 1;
  localparam int          DEPTH = 2 ** AW;

  logic clk_6M = 1'b0;
  logic rstz;

  acl_txbuf_ctrl_if #(.AW(AW)) bus ();

  acl_txbuf_ctrl #(.AW(AW)) dut (
    .clk_6M (clk_6M),
    .rstz   (rstz),
    .bus    (bus.slave)
  );

  always #5 clk_6M = ~clk_6M;

  int n_tests = 0;
  int n_fail  = 0;

  // model: bytes written since last commit, committed payload, un-ACKed payload
  logic [7:0] fill_q[$];
  logic [7:0] pend_q[$];
  logic [7:0] cur_q[$];
  bit         pend_v, cur_v, ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.m_2active_p    = 1'b0;
    bus.s_2active_p    = 1'b0;
    bus.mcu_wr_p       = 1'b0;
    bus.mcu_commit_p   = 1'b0;
    bus.mcu_flush_p    = 1'b0;
    bus.pk_encode      = 1'b0;
    bus.header_st_p    = 1'b0;
    bus.txpktype_data  = 1'b0;
    bus.sendnewpy      = 1'b0;
    bus.sendoldpy      = 1'b0;
    bus.send0py        = 1'b0;
    bus.py_rd_p        = 1'b0;
    bus.ms_TXslot_endp = 1'b0;
  endtask

  // one clock; inputs driven beforehand are sampled, outputs observed 1 time unit later
  task automatic step();
    @(posedge clk_6M);
    #1;
    idle_inputs();
  endtask

  task automatic check_status(input string tag);
    check({tag, ".fill_full"}, 32'(bus.fill_full), 32'(pend_v));
    check({tag, ".cur_valid"}, 32'(bus.cur_valid), 32'(cur_v));
    check({tag, ".ovf_err"},   32'(bus.ovf_err),   32'(ovf));
  endtask

  task automatic model_reset();
    fill_q.delete(); pend_q.delete(); cur_q.delete();
    pend_v = 0; cur_v = 0; ovf = 0;
  endtask

  // busy = pending occupied before the edge
  task automatic model_commit(input int len, input bit busy);
    int n;
    if (busy) begin
      ovf = 1;
    end else begin
      n = (len > DEPTH) ? DEPTH : len;
      pend_q.delete();
      for (int i = 0; i < n; i++) pend_q.push_back(fill_q[i]);
      pend_v = 1;
      fill_q.delete();
    end
  endtask

  function automatic int pick_len();
    int s = fill_q.size();
    return (s == DEPTH) ? int'($urandom_range(0, DEPTH + 1)) : int'($urandom_range(0, s));
  endfunction

  task automatic do_write(input logic [7:0] b);
    bus.mcu_wr_p  = 1'b1;
    bus.mcu_wdata = b;
    step();
    if (pend_v || fill_q.size() == DEPTH) ovf = 1;
    else fill_q.push_back(b);
    check_status("write");
  endtask

  task automatic do_commit(input int len);
    bus.mcu_commit_p   = 1'b1;
    bus.mcu_commit_len = LW'(len);
    step();
    model_commit(len, pend_v);
    check_status("commit");
  endtask

  task automatic do_flush();
    bus.mcu_flush_p = 1'b1;
    step();
    pend_v = 0; fill_q.delete(); ovf = 0;
    check_status("flush");
  endtask

  task automatic do_connect();
    if ($urandom_range(0, 1) == 0) bus.m_2active_p = 1'b1;
    else                           bus.s_2active_p = 1'b1;
    step();
    model_reset();
    check("connect.py_valid", 32'(bus.py_valid), 32'd0);
    check("connect.py_byte",  32'(bus.py_byte),  32'd0);
    check_status("connect");
  endtask

  // header with decision vector {zero,old,new}; abort_mode 0 none, 1 slot end, 2 connect
  task automatic do_packet(input logic [2:0] dvec, input bit with_commit, input int clen,
                           input int abort_at, input int abort_mode);
    bit         busy;
    int         exp_len;
    logic [7:0] exp_q[$];
    bus.header_st_p   = 1'b1;
    bus.pk_encode     = 1'b1;
    bus.txpktype_data = 1'b1;
    bus.sendnewpy     = dvec[0];
    bus.sendoldpy     = dvec[1];
    bus.send0py       = dvec[2];
    if (with_commit) begin
      bus.mcu_commit_p   = 1'b1;
      bus.mcu_commit_len = LW'(clen);
    end
    step();
    busy = pend_v;
    if (dvec[0] && pend_v) begin
      cur_q = pend_q; cur_v = 1; pend_v = 0; exp_len = cur_q.size();
    end else if (dvec[0]) begin
      cur_v = 0; exp_len = 0;
    end else if (dvec[1]) begin
      exp_len = cur_v ? cur_q.size() : 0;
    end else begin
      if (dvec[2]) cur_v = 0;
      exp_len = 0;
    end
    if (with_commit) model_commit(clen, busy);
    exp_q.delete();
    if (exp_len > 0) exp_q = cur_q;

    check("hdr.py_valid", 32'(bus.py_valid), 32'd1);
    check("hdr.py_len",   32'(bus.py_len),   32'(exp_len));
    check_status("hdr");

    if (exp_len == 0) begin
      check("zlen.py_byte", 32'(bus.py_byte), 32'd0);
      bus.py_rd_p = 1'($urandom_range(0, 1));
      step();
      check("zlen.py_valid", 32'(bus.py_valid),  32'd0);
      check("zlen.py_last",  32'(bus.py_last_p), 32'd0);
      return;
    end

    for (int i = 0; i < exp_len; i++) begin
      if (abort_mode != 0 && i == abort_at) begin
        if (abort_mode == 2) begin
          do_connect();
        end else begin
          bus.ms_TXslot_endp = 1'b1;
          step();
          check("abort.py_valid", 32'(bus.py_valid),  32'd0);
          check("abort.py_byte",  32'(bus.py_byte),   32'd0);
          check("abort.py_last",  32'(bus.py_last_p), 32'd0);
        end
        return;
      end
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        step();
        check("gap.py_byte", 32'(bus.py_byte), 32'(exp_q[i]));
      end
      check("rd.py_byte", 32'(bus.py_byte), 32'(exp_q[i]));
      bus.py_rd_p = 1'b1;
      step();
      check("rd.py_last",  32'(bus.py_last_p), (i == exp_len - 1) ? 32'd1 : 32'd0);
      check("rd.py_valid", 32'(bus.py_valid),  (i == exp_len - 1) ? 32'd0 : 32'd1);
    end
    check("end.py_byte", 32'(bus.py_byte), 32'd0);
    step();
    check("end.py_last", 32'(bus.py_last_p), 32'd0);
  endtask

  task automatic do_ignored_hdr();
    logic [1:0] q;
    q = 2'($urandom_range(0, 2));
    bus.header_st_p   = 1'b1;
    bus.pk_encode     = q[0];
    bus.txpktype_data = q[1];
    bus.sendnewpy     = 1'($urandom);
    bus.sendoldpy     = 1'($urandom);
    bus.py_rd_p       = 1'b1;
    step();
    check("ign.py_valid", 32'(bus.py_valid), 32'd0);
    check("ign.py_byte",  32'(bus.py_byte),  32'd0);
    check_status("ign");
  endtask

  int r;

  initial begin
    idle_inputs();
    bus.mcu_wdata      = 8'h00;
    bus.mcu_commit_len = '0;
    model_reset();
    rstz = 1'b0;
    repeat (3) @(posedge clk_6M);
    #1;
    check("rst.py_valid", 32'(bus.py_valid),  32'd0);
    check("rst.py_len",   32'(bus.py_len),    32'd0);
    check("rst.py_byte",  32'(bus.py_byte),   32'd0);
    check("rst.py_last",  32'(bus.py_last_p), 32'd0);
    check_status("rst");
    rstz = 1'b1;
    step();

    // new payload, retransmit, then sendnewpy with nothing pending
    do_write(8'hA1); do_write(8'hA2); do_write(8'hA3);
    do_commit(3);
    do_packet(3'b001, 0, 0, 0, 0);
    do_packet(3'b010, 0, 0, 0, 0);
    do_packet(3'b001, 0, 0, 0, 0);

    // refused commit, flush, 33rd byte, oversize commit length
    do_write(8'h11); do_write(8'h22);
    do_commit(2);
    do_commit(2);
    do_flush();
    for (int i = 0; i < DEPTH + 1; i++) do_write(8'(i + 8'h40));
    do_flush();
    for (int i = 0; i < DEPTH; i++) do_write(8'($urandom));
    do_commit(DEPTH + 1);
    do_packet(3'b111, 0, 0, 0, 0);

    // commit in the header cycle is seen only by the next packet
    do_write(8'hB1); do_write(8'hB2);
    do_packet(3'b001, 1, 2, 0, 0);
    do_packet(3'b001, 0, 0, 0, 0);

    // slot end after one byte, then retransmit from byte 0
    do_write(8'hC1); do_write(8'hC2); do_write(8'hC3);
    do_commit(3);
    do_packet(3'b001, 0, 0, 1, 1);
    do_packet(3'b010, 0, 0, 0, 0);

    // connect mid-read with a pending payload, then normal use after
    do_write(8'hD1); do_write(8'hD2);
    do_commit(2);
    do_packet(3'b010, 0, 0, 1, 2);
    do_write(8'hE1); do_write(8'hE2);
    do_commit(2);
    do_packet(3'b001, 0, 0, 0, 0);

    for (int it = 0; it < 400; it++) begin
      r = int'($urandom_range(0, 99));
      if (r < 40)      do_write(8'($urandom));
      else if (r < 52) do_commit(pick_len());
      else if (r < 58) do_flush();
      else if (r < 88) do_packet(3'($urandom), ($urandom_range(0, 5) == 0), pick_len(),
                                 int'($urandom_range(0, DEPTH)),
                                 ($urandom_range(0, 9) == 0) ? 1 :
                                 ($urandom_range(0, 19) == 0) ? 2 : 0);
      else if (r < 97) do_ignored_hdr();
      else             do_connect();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
